// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module : bus_arbiter_if
// Brief  : Request/grant handshake and shared memory-port bundle for bus_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic                 ena;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      done;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_we;
    logic [NREQ-1:0]      gnt;
    logic [2:0]           gnt_id;
    logic                 busy;
    logic                 timeout_err;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_we;

    modport master (
        output ena, req, done, req_addr, req_wdata, req_we,
        input  gnt, gnt_id, busy, timeout_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  ena, req, done, req_addr, req_wdata, req_we,
        output gnt, gnt_id, busy, timeout_err, mem_addr, mem_wdata, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin arbiter with owner timeout and memory-port mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bus_arbiter_if.slave    bus
);
    localparam int c_TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [NREQ-1:0]    r_gnt,     w_gnt_nxt;
    logic [2:0]         r_gnt_id,  w_gnt_id_nxt;
    logic [2:0]         r_rr_ptr,  w_rr_nxt;
    logic [c_TW-1:0]    r_timer,   w_timer_nxt;
    logic               r_terr,    w_terr_nxt;

    logic               w_own_req;
    logic               w_own_done;
    logic               w_found;
    logic [2:0]         w_pick;
    logic [NREQ-1:0]    w_onehot;
    int                 w_best;
    int                 w_dist;
    logic [AW-1:0]      w_mem_addr;
    logic [DW-1:0]      w_mem_wdata;
    logic               w_mem_we;

    // Owner's handshake bits and memory fields, selected from registered gnt_id
    always_comb begin
        w_own_req   = 1'b0;
        w_own_done  = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt_id == 3'(i)) begin
                w_own_req  = bus.req[i];
                w_own_done = bus.done[i];
                if (r_state == ST_OWN) begin
                    w_mem_addr  = bus.req_addr[i*AW +: AW];
                    w_mem_wdata = bus.req_wdata[i*DW +: DW];
                    w_mem_we    = bus.req_we[i];
                end
            end
        end
    end

    // Closest requester after rr_ptr in circular order wins
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_best   = NREQ;
        w_dist   = 0;
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i - int'(r_rr_ptr) - 1 + 2 * NREQ) % NREQ;
            if (bus.req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_pick  = 3'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == 3'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_rr_nxt     = r_rr_ptr;
        w_timer_nxt  = r_timer;
        w_terr_nxt   = 1'b0;
        case (r_state)
            ST_OWN: begin
                if (w_own_done || !w_own_req) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = '0;
                end else if ((TIMEOUT != 0) && (r_timer == c_TLAST)) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = '0;
                    w_terr_nxt  = 1'b1;
                end else if (r_timer != '1) begin
                    w_timer_nxt = r_timer + c_TW'(1);
                end
            end
            default: begin
                if (bus.ena && w_found) begin
                    w_state_nxt  = ST_OWN;
                    w_gnt_nxt    = w_onehot;
                    w_gnt_id_nxt = w_pick;
                    w_rr_nxt     = w_pick;
                    w_timer_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_rr_ptr <= 3'(NREQ - 1);
            r_timer  <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_timer  <= w_timer_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.gnt_id      = r_gnt_id;
    assign bus.busy        = (r_state == ST_OWN);
    assign bus.timeout_err = r_terr;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_we      = w_mem_we;
endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Self-checking bench for bus_arbiter (vector table, corner sequences, random vs model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;
    localparam int NREQ    = 4;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic            ena;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] done;
        logic [NREQ-1:0] egnt;
        int              eid;
        logic            ebusy;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected memory fields come from the bench's own view of who owns the bus
    task automatic chk_out(input string tag, input logic [NREQ-1:0] egnt, input int eid,
                           input logic ebusy, input logic eterr);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        ea = '0; ed = '0; ew = 1'b0;
        if (ebusy) begin
            ea = bus.req_addr[eid*AW +: AW];
            ed = bus.req_wdata[eid*DW +: DW];
            ew = bus.req_we[eid];
        end
        chk({tag, " gnt"},       32'(bus.gnt),         32'(egnt));
        chk({tag, " gnt_id"},    32'(bus.gnt_id),      32'(eid));
        chk({tag, " busy"},      32'(bus.busy),        32'(ebusy));
        chk({tag, " tmo_err"},   32'(bus.timeout_err), 32'(eterr));
        chk({tag, " mem_addr"},  32'(bus.mem_addr),    32'(ea));
        chk({tag, " mem_wdata"}, 32'(bus.mem_wdata),   32'(ed));
        chk({tag, " mem_we"},    32'(bus.mem_we),      32'(ew));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.ena       = 1'b1;
        bus.req       = '0;
        bus.done      = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_we    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: owner index (-1 = none), round-robin pointer, cycles owned
    int   m_owner, m_ptr, m_last, m_cnt;
    logic m_terr;

    task automatic model_reset();
        m_owner = -1; m_ptr = NREQ - 1; m_last = 0; m_cnt = 0; m_terr = 1'b0;
    endtask

    task automatic model_step(input logic ena, input logic [NREQ-1:0] req,
                              input logic [NREQ-1:0] done);
        bit found;
        int c;
        m_terr = 1'b0;
        if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner]) begin
                m_owner = -1;
            end else if (TIMEOUT != 0 && m_cnt == TIMEOUT - 1) begin
                m_owner = -1;
                m_terr  = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (ena) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!found && req[c]) begin
                    found = 1; m_owner = c; m_ptr = c; m_last = c; m_cnt = 0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] d;

        //               ena   req      done     egnt     id  busy
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 0, 1'b1};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 1, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 4'b0010, 4'b0000, 1, 1'b0};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 4'b0100, 4'b0000, 2, 1'b0};
        tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 3, 1'b1};
        tbl[7]  = '{1'b1, 4'b1111, 4'b1000, 4'b0000, 3, 1'b0};
        tbl[8]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 0, 1'b1};
        tbl[9]  = '{1'b1, 4'b1111, 4'b0010, 4'b0001, 0, 1'b1};
        tbl[10] = '{1'b1, 4'b1110, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[12] = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 0, 1'b0};
        tbl[13] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[14] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2, 1'b1};

        // Reset state, then T1 single requester with one-cycle gap after done
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.req = 4'b0001;
        tick(); chk_out("T1 grant", 4'b0001, 0, 1'b1, 1'b0);
        bus.done = 4'b0001;
        tick(); chk_out("T1 done", 4'b0000, 0, 1'b0, 1'b0);
        bus.done = 4'b0000;
        tick(); chk_out("T1 regrant", 4'b0001, 0, 1'b1, 1'b0);

        // Vector table: round-robin order, stray done, drop-out, ena gating
        do_reset();
        bus.req_addr  = 16'hC963;
        bus.req_wdata = 32'hD4A75E31;
        bus.req_we    = 4'b1010;
        for (int i = 0; i < 15; i++) begin
            bus.ena  = tbl[i].ena;
            bus.req  = tbl[i].req;
            bus.done = tbl[i].done;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].egnt, tbl[i].eid, tbl[i].ebusy, 1'b0);
        end

        // T3 timeout: requester 2 never finishes, 3 waits behind it
        do_reset();
        bus.req = 4'b1100;
        cnt = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (bus.timeout_err) seen = 1;
            else if (bus.gnt == 4'b0100) cnt++;
        end
        chk("T3 timeout seen", 32'(seen), 32'd1);
        chk("T3 hold cycles", 32'(cnt), 32'(TIMEOUT));
        chk_out("T3 release", 4'b0000, 2, 1'b0, 1'b1);
        tick(); chk_out("T3 next", 4'b1000, 3, 1'b1, 1'b0);

        // T4 mux contents, then drop req without done
        do_reset();
        bus.req_addr  = 16'h37A1;
        bus.req_wdata = 32'h11225C99;
        bus.req_we    = 4'b1111;
        bus.req       = 4'b0010;
        tick();
        chk_out("T4 own", 4'b0010, 1, 1'b1, 1'b0);
        chk("T4 addr A", 32'(bus.mem_addr), 32'hA);
        chk("T4 wdata 5C", 32'(bus.mem_wdata), 32'h5C);
        bus.req = 4'b0000;
        tick(); chk_out("T4 drop", 4'b0000, 1, 1'b0, 1'b0);

        // T5 asynchronous reset in the middle of ownership
        do_reset();
        bus.req = 4'b0001; bus.req_we = 4'b0001; bus.req_addr = 16'h0005;
        tick(); chk_out("T5 own", 4'b0001, 0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("T5 async rst", 4'b0000, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req = 4'b0010;
        tick(); chk_out("T5 after", 4'b0010, 1, 1'b1, 1'b0);

        // T6 ena low blocks grants
        do_reset();
        bus.ena = 1'b0; bus.req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("T6 blocked gnt", 32'(bus.gnt), 32'd0);
        end
        bus.ena = 1'b1;
        tick(); chk_out("T6 enabled", 4'b0100, 2, 1'b1, 1'b0);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        r = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r[i]) r[i] = ($urandom_range(0, 99) < 30);
                else       r[i] = !($urandom_range(0, 99) < 5);
            end
            d = '0;
            for (int i = 0; i < NREQ; i++) d[i] = ($urandom_range(0, 99) < 5);
            if (m_owner >= 0 && $urandom_range(0, 99) < 10) d[m_owner] = 1'b1;
            bus.req       = r;
            bus.done      = d;
            bus.ena       = ($urandom_range(0, 9) != 0);
            bus.req_addr  = NREQ*AW'($urandom);
            bus.req_wdata = NREQ*DW'($urandom);
            bus.req_we    = NREQ'($urandom);
            tick();
            model_step(bus.ena, r, d);
            chk_out($sformatf("rand%0d", cyc),
                    (m_owner >= 0) ? NREQ'(1) << m_owner : '0,
                    m_last, (m_owner >= 0), m_terr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
